// File: rtl/if_stage_pkg.sv
// rtl/if_stage_pkg.sv - shared constants for the instruction fetch stage
package if_stage_pkg;

  localparam logic [1:0] PC_SEQ = 2'b00;
  localparam logic [1:0] PC_BR  = 2'b01;
  localparam logic [1:0] PC_JR  = 2'b10;
  localparam logic [1:0] PC_J   = 2'b11;

  localparam logic [31:0] NOP       = 32'h0000_0000;
  localparam int          ROM_DEPTH = 64;
  localparam int          ROM_AW    = 6;
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;

endpackage

// File: rtl/inst_rom.sv
// rtl/inst_rom.sv - 64-word combinational instruction ROM
// Contents come from the fixed init table below; unlisted words hold a 0x2000_00xx tag pattern.
module inst_rom
  import if_stage_pkg::*;
(
  input  logic [ROM_AW-1:0] addr,
  output logic [31:0]       data
);

  always_comb begin
    data = {16'h2000, 10'h000, addr};
    case (addr)
      6'd0: data = 32'h3c01_0000;
      6'd1: data = 32'h3424_0050;
      6'd2: data = 32'h2005_0004;
      6'd3: data = 32'h0c00_0018;
      6'd4: data = 32'hac82_0000;
      6'd5: data = 32'h8c89_0000;
      default: ;
    endcase
  end

endmodule

// File: rtl/if_stage.sv
// rtl/if_stage.sv - PC register, next-PC select and IF/ID pipeline register
// Optional macro IF_FLUSH_EN squashes the wrong-path instruction on a redirect.
module if_stage
  import if_stage_pkg::*;
(
  input  logic        clk,
  input  logic        clrn,
  input  logic        stall,
  input  logic [1:0]  pcsource,
  input  logic [31:0] bpc,
  input  logic [31:0] ra,
  input  logic [31:0] jpc,
  output logic [31:0] pc,
  output logic [31:0] if_pc4,
  output logic [31:0] id_pc4,
  output logic [31:0] id_inst,
  output logic        id_valid,
  output logic [31:0] fetch_count
);

  logic [31:0] npc_raw;
  logic [31:0] npc;
  logic [31:0] inst;
  logic        redirect;

  inst_rom u_rom (
    .addr (pc[7:2]),
    .data (inst)
  );

  assign if_pc4   = pc + 32'd4;
  assign redirect = (pcsource != PC_SEQ);

  always_comb begin
    npc_raw = if_pc4;
    case (pcsource)
      PC_SEQ:  npc_raw = if_pc4;
      PC_BR:   npc_raw = bpc;
      PC_JR:   npc_raw = ra;
      PC_J:    npc_raw = jpc;
      default: npc_raw = if_pc4;
    endcase
    npc = {npc_raw[31:2], 2'b00};
  end

  // All id_* outputs are registered, so stall/pcsource never reach them combinationally.
  always_ff @(posedge clk) begin
    if (!clrn) begin
      pc          <= RESET_PC;
      id_pc4      <= 32'h0;
      id_inst     <= NOP;
      id_valid    <= 1'b0;
      fetch_count <= 32'h0;
    end else if (!stall) begin
      pc          <= npc;
      id_pc4      <= if_pc4;
      fetch_count <= fetch_count + 32'd1;
`ifdef IF_FLUSH_EN
      if (redirect) begin
        id_inst  <= NOP;
        id_valid <= 1'b0;
      end else begin
        id_inst  <= inst;
        id_valid <= 1'b1;
      end
`else
      id_inst  <= inst;
      id_valid <= 1'b1;
`endif
    end
  end

`ifndef IF_FLUSH_EN
  // Delay-slot build: the redirect flag only steers npc.
  logic unused_redirect;
  assign unused_redirect = redirect;
`endif

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - directed self-checking bench for if_stage
module tb_if_stage;

  logic        clk = 1'b0;
  logic        clrn;
  logic        stall;
  logic [1:0]  pcsource;
  logic [31:0] bpc, ra, jpc;
  logic [31:0] pc, if_pc4, id_pc4, id_inst, fetch_count;
  logic        id_valid;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  if_stage dut (
    .clk         (clk),
    .clrn        (clrn),
    .stall       (stall),
    .pcsource    (pcsource),
    .bpc         (bpc),
    .ra          (ra),
    .jpc         (jpc),
    .pc          (pc),
    .if_pc4      (if_pc4),
    .id_pc4      (id_pc4),
    .id_inst     (id_inst),
    .id_valid    (id_valid),
    .fetch_count (fetch_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  initial begin
    clrn = 1'b0; stall = 1'b1; pcsource = 2'b11;
    bpc = 32'h0; ra = 32'h0; jpc = 32'h80;
    tick(2);
    check("rst_pc", pc, 32'h0);
    check("rst_valid", {31'b0, id_valid}, 32'h0);
    check("rst_count", fetch_count, 32'h0);
    check("rst_inst", id_inst, 32'h0);
    check("rst_pc4", id_pc4, 32'h0);

    clrn = 1'b1; stall = 1'b0; pcsource = 2'b00;
    tick(3);
    check("seq_pc", pc, 32'h0C);
    check("seq_id_pc4", id_pc4, 32'h0C);
    check("seq_count", fetch_count, 32'd3);
    check("seq_inst", id_inst, 32'h2005_0004);
    check("seq_valid", {31'b0, id_valid}, 32'h1);
    check("seq_if_pc4", if_pc4, 32'h10);

    tick(1);
    check("pre_stall_pc", pc, 32'h10);

    stall = 1'b1;
    tick(3);
    check("stall_pc", pc, 32'h10);
    check("stall_inst", id_inst, 32'h0c00_0018);
    check("stall_pc4", id_pc4, 32'h10);
    check("stall_count", fetch_count, 32'd4);
    stall = 1'b0;
    tick(1);
    check("unstall_pc", pc, 32'h14);
    check("unstall_inst", id_inst, 32'hac82_0000);
    check("unstall_count", fetch_count, 32'd5);

    pcsource = 2'b11; jpc = 32'h08;
    tick(1);
    check("jmp8_pc", pc, 32'h08);

    pcsource = 2'b01; bpc = 32'h40;
    tick(1);
    check("br_pc", pc, 32'h40);
    check("br_pc4", id_pc4, 32'h0C);
    check("br_count", fetch_count, 32'd7);
`ifdef IF_FLUSH_EN
    check("br_inst", id_inst, 32'h0);
    check("br_valid", {31'b0, id_valid}, 32'h0);
`else
    check("br_inst", id_inst, 32'h2005_0004);
    check("br_valid", {31'b0, id_valid}, 32'h1);
`endif

    pcsource = 2'b00;
    tick(1);
    check("after_br_pc", pc, 32'h44);
    check("after_br_inst", id_inst, 32'h2000_0010);
    check("after_br_valid", {31'b0, id_valid}, 32'h1);

    stall = 1'b1; pcsource = 2'b11; jpc = 32'h80;
    tick(1);
    check("stalljmp_pc", pc, 32'h44);
    check("stalljmp_count", fetch_count, 32'd8);
    stall = 1'b0;
    tick(1);
    check("jmp_pc", pc, 32'h80);
    check("jmp_count", fetch_count, 32'd9);

    pcsource = 2'b10; ra = 32'h0000_0123;
    tick(1);
    check("jr_pc", pc, 32'h120);
`ifndef IF_FLUSH_EN
    check("jr_inst", id_inst, 32'h2000_0020);
`endif

    pcsource = 2'b11; jpc = 32'hFFFF_FFFC;
    tick(1);
    check("wrap_pc", pc, 32'hFFFF_FFFC);
    check("wrap_if_pc4", if_pc4, 32'h0);
    pcsource = 2'b00;
    tick(1);
    check("wrap_next_pc", pc, 32'h0);
    check("wrap_id_pc4", id_pc4, 32'h0);
    check("wrap_inst", id_inst, 32'h2000_003F);
    check("wrap_count", fetch_count, 32'd12);

    pcsource = 2'b11; jpc = 32'h100;
    tick(1);
    pcsource = 2'b00;
    tick(1);
    check("alias_inst", id_inst, 32'h3c01_0000);
    check("alias_pc4", id_pc4, 32'h104);

    clrn = 1'b0; stall = 1'b1; pcsource = 2'b11; jpc = 32'h80;
    tick(1);
    check("midrst_pc", pc, 32'h0);
    check("midrst_valid", {31'b0, id_valid}, 32'h0);
    check("midrst_count", fetch_count, 32'h0);
    clrn = 1'b1; stall = 1'b0; pcsource = 2'b00;
    tick(1);
    check("postrst_pc", pc, 32'h04);
    check("postrst_pc4", id_pc4, 32'h04);
    check("postrst_inst", id_inst, 32'h3c01_0000);
    check("postrst_count", fetch_count, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
